mem_port_arbiter: RTL and testbench

- Shares one downstream memory port between the core's instruction bus (ibus) and data bus (dbus).
- Sits between core and the memory/bridge; core ireq/dreq enter here, a single cbus-style request leaves.
- Sequences one outstanding transaction at a time: grant, latch request, wait for address accept, wait for data, return response to the owner.
- Default priority is dbus over ibus, because the memory-stage instruction is older than the fetch.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the ibus/dbus memory port arbiter.
// The request record is sized for the widest supported port (64-bit address
// and data); narrower instances zero-extend into it and slice back out.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_DATA_W = 64;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    // msize encoding: 0=1B, 1=2B, 2=4B, 3=8B; instruction fetches are 4 bytes
    localparam logic [2:0] MSIZE4 = 3'd2;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_DATA
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [ARB_STRB_W-1:0] strobe;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between the instruction bus and the
// data bus, one outstanding transaction at a time.
// Default priority is dbus over ibus (the memory-stage access is older than
// the fetch). Define MEM_PORT_ARB_RR_EN to break ties round-robin instead.
// Response pulses and read data are combinational from m_addr_ok/m_data_ok so
// they land in the same cycle the downstream side reports them; every output
// is forced to zero while reset is high.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    // instruction bus
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    // data bus
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_size,
    input  logic [STRB_W-1:0] d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    // downstream port
    output logic              m_valid,
    output logic              m_is_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [STRB_W-1:0] m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t r_state;
    owner_t     r_owner;
    arb_req_t   r_req;

    owner_t     w_grant;
    arb_req_t   w_sel_req;
    logic       w_live;
    logic       w_in_req;
    logic       w_addr_acc;
    logic       w_done;
    logic       w_own_i;
    logic       w_own_d;

`ifdef MEM_PORT_ARB_RR_EN
    logic       r_last_is_d;    // 0 = ibus finished last (reset value)
`endif

    // Priority select among the two requesters; only consulted in IDLE
    always_comb begin
        w_grant = OWN_NONE;
        if (d_valid && i_valid) begin
`ifdef MEM_PORT_ARB_RR_EN
            w_grant = r_last_is_d ? OWN_I : OWN_D;
`else
            w_grant = OWN_D;
`endif
        end else if (d_valid) begin
            w_grant = OWN_D;
        end else if (i_valid) begin
            w_grant = OWN_I;
        end
    end

    // Build the request record for the winner; ibus is always a 4-byte read
    always_comb begin
        w_sel_req = '0;
        if (w_grant == OWN_D) begin
            w_sel_req.addr   = ARB_ADDR_W'(d_addr);
            w_sel_req.size   = d_size;
            w_sel_req.strobe = ARB_STRB_W'(d_strobe);
            w_sel_req.wdata  = ARB_DATA_W'(d_wdata);
        end else if (w_grant == OWN_I) begin
            w_sel_req.addr   = ARB_ADDR_W'(i_addr);
            w_sel_req.size   = MSIZE4;
        end
    end

    assign w_live     = ~reset;
    assign w_in_req   = (r_state == ARB_REQ);
    assign w_addr_acc = w_in_req & m_addr_ok;
    assign w_done     = (w_addr_acc & m_data_ok) | ((r_state == ARB_DATA) & m_data_ok);
    assign w_own_i    = (r_owner == OWN_I);
    assign w_own_d    = (r_owner == OWN_D);

    // Transaction sequencer: grant/latch, wait address accept, wait data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_NONE;
            r_req   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant != OWN_NONE) begin
                        r_req   <= w_sel_req;
                        r_owner <= w_grant;
                        r_state <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (m_addr_ok) begin
                        if (m_data_ok) begin
                            r_owner <= OWN_NONE;
                            r_state <= ARB_IDLE;
                        end else begin
                            r_state <= ARB_DATA;
                        end
                    end
                end
                ARB_DATA: begin
                    if (m_data_ok) begin
                        r_owner <= OWN_NONE;
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_PORT_ARB_RR_EN
    // Remember who finished last; abandoned (reset) transactions don't count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_is_d <= 1'b0;
        end else if (w_done) begin
            r_last_is_d <= w_own_d;
        end
    end
`endif

    // Downstream request is only driven while waiting for address accept
    assign m_valid    = w_live & w_in_req;
    assign m_is_write = m_valid & (|r_req.strobe);
    assign m_addr     = m_valid ? r_req.addr[ADDR_W-1:0]   : '0;
    assign m_size     = m_valid ? r_req.size               : '0;
    assign m_strobe   = m_valid ? r_req.strobe[STRB_W-1:0] : '0;
    assign m_wdata    = m_valid ? r_req.wdata[DATA_W-1:0]  : '0;

    // Responses steered to the owner only; the other side stays quiet
    assign i_addr_ok  = w_live & w_addr_acc & w_own_i;
    assign i_data_ok  = w_live & w_done & w_own_i;
    assign i_rdata    = i_data_ok ? m_rdata : '0;
    assign d_addr_ok  = w_live & w_addr_acc & w_own_d;
    assign d_data_ok  = w_live & w_done & w_own_d;
    assign d_rdata    = d_data_ok ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle table, a round-robin tie
// sequence when MEM_PORT_ARB_RR_EN is defined, then randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 8;

    localparam logic [63:0] IADDR = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DADDR = 64'h0000_0000_8000_1000;
    localparam logic [2:0]  DSIZE = 3'd3;
    localparam logic [63:0] DWD   = 64'h1122_3344_5566_7788;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          i_valid, i_addr_ok, i_data_ok;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_valid, d_addr_ok, d_data_ok;
    logic [AW-1:0] d_addr;
    logic [2:0]    d_size;
    logic [SW-1:0] d_strobe;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_valid, m_is_write, m_addr_ok, m_data_ok;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_size;
    logic [SW-1:0] m_strobe;
    logic [DW-1:0] m_wdata, m_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size),
        .d_strobe(d_strobe), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
        .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr),
        .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    typedef logic [272:0] obs_t;
    obs_t got;
    assign got = {m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata,
                  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata};

    int n_checks = 0;
    int n_err    = 0;

    function automatic obs_t mk(bit mv, bit mw, logic [63:0] ma, logic [2:0] ms,
                                logic [7:0] mst, logic [63:0] mwd,
                                bit ia, bit id, logic [63:0] ir,
                                bit da, bit dd, logic [63:0] dr);
        return {mv, mw, ma, ms, mst, mwd, ia, id, ir, da, dd, dr};
    endfunction

    task automatic check(string name, obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        bit          rst, iv, dv;
        logic [7:0]  dstrb;
        bit          maok, mdok;
        logic [63:0] mrd;
        bit          mv, mw, own_d;
        bit          iaok, idok;
        logic [63:0] irdata;
        bit          daok, ddok;
        logic [63:0] drdata;
    } vec_t;

    function automatic vec_t v(bit rst, bit iv, bit dv, logic [7:0] dstrb,
                               bit maok, bit mdok, logic [63:0] mrd,
                               bit mv, bit mw, bit own_d,
                               bit iaok, bit idok, logic [63:0] irdata,
                               bit daok, bit ddok, logic [63:0] drdata);
        vec_t r;
        r.rst = rst; r.iv = iv; r.dv = dv; r.dstrb = dstrb;
        r.maok = maok; r.mdok = mdok; r.mrd = mrd;
        r.mv = mv; r.mw = mw; r.own_d = own_d;
        r.iaok = iaok; r.idok = idok; r.irdata = irdata;
        r.daok = daok; r.ddok = ddok; r.drdata = drdata;
        return r;
    endfunction

    vec_t vecs[$];

    // random-phase model state
    int          mph;      // 0 port free, 1 request offered, 2 awaiting data
    int          own;      // 0 none, 1 ibus, 2 dbus
    bit          last_d;
    logic [63:0] e_addr, e_wdata;
    logic [2:0]  e_size;
    logic [7:0]  e_strb;

    initial begin
        reset = 1'b1;
        i_valid = 0; i_addr = IADDR;
        d_valid = 0; d_addr = DADDR; d_size = DSIZE; d_strobe = 0; d_wdata = DWD;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;

        // reset with ibus pending, then an ibus read (accept after 2, data 3 later)
        vecs.push_back(v(1,1,0,8'h00, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(1,1,0,8'h00, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,1,0,8'h00, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,1,0,8'h00, 0,0,0,              1,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,1,0,8'h00, 0,0,0,              1,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,1,0,8'h00, 1,0,0,              1,0,0, 1,0,0,              0,0,0));
        vecs.push_back(v(0,1,0,8'h00, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,1,0,8'h00, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,1,0,8'h00, 0,1,64'hDEADBEEF,   0,0,0, 0,1,64'hDEADBEEF,   0,0,0));
        vecs.push_back(v(0,0,0,8'h00, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        // tie: dbus write first, then ibus
        vecs.push_back(v(0,1,1,8'hFF, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,1,1,8'hFF, 1,0,0,              1,1,1, 0,0,0,              1,0,0));
        vecs.push_back(v(0,1,1,8'hFF, 0,1,64'h55,         0,0,0, 0,0,0,              0,1,64'h55));
        vecs.push_back(v(0,1,0,8'hFF, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,1,0,8'hFF, 1,1,64'hA5,         1,0,0, 1,1,64'hA5,         0,0,0));
        vecs.push_back(v(0,0,0,8'hFF, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        // dbus read with same-cycle address accept and data
        vecs.push_back(v(0,0,1,8'h00, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,0,1,8'h00, 1,1,64'h1234,       1,0,1, 0,0,0,              1,1,64'h1234));
        vecs.push_back(v(0,0,0,8'h00, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        // reset while awaiting data, with m_data_ok in the same cycle
        vecs.push_back(v(0,0,1,8'hFF, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,0,1,8'hFF, 1,0,0,              1,1,1, 0,0,0,              1,0,0));
        vecs.push_back(v(1,0,1,8'hFF, 0,1,64'h77,         0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,0,0,8'hFF, 0,0,0,              0,0,0, 0,0,0,              0,0,0));
        vecs.push_back(v(0,0,0,8'hFF, 0,1,64'h99,         0,0,0, 0,0,0,              0,0,0));

        foreach (vecs[k]) begin
            logic [63:0] pa, pw;
            logic [2:0]  ps;
            logic [7:0]  pst;
            @(negedge clk);
            reset = vecs[k].rst; i_valid = vecs[k].iv; d_valid = vecs[k].dv;
            d_strobe = vecs[k].dstrb; m_addr_ok = vecs[k].maok;
            m_data_ok = vecs[k].mdok; m_rdata = vecs[k].mrd;
            pa = 0; ps = 0; pst = 0; pw = 0;
            if (vecs[k].mv) begin
                if (vecs[k].own_d) begin
                    pa = DADDR; ps = DSIZE; pst = vecs[k].dstrb; pw = DWD;
                end else begin
                    pa = IADDR; ps = MSIZE4;
                end
            end
            #1;
            check($sformatf("vec%0d", k),
                  mk(vecs[k].mv, vecs[k].mw, pa, ps, pst, pw,
                     vecs[k].iaok, vecs[k].idok, vecs[k].irdata,
                     vecs[k].daok, vecs[k].ddok, vecs[k].drdata));
        end

`ifdef MEM_PORT_ARB_RR_EN
        // three back-to-back ties alternate starting with dbus
        @(negedge clk);
        reset = 1; i_valid = 0; d_valid = 0; m_addr_ok = 0; m_data_ok = 0;
        for (int t = 0; t < 3; t++) begin
            bit exp_d;
            exp_d = (t != 1);
            @(negedge clk);
            reset = 0; i_valid = 1; d_valid = 1; d_strobe = 0;
            m_addr_ok = 0; m_data_ok = 0;
            @(negedge clk);
            m_addr_ok = 1; m_data_ok = 1; m_rdata = 64'(t);
            #1;
            n_checks++;
            if (d_addr_ok !== exp_d || i_addr_ok !== !exp_d) begin
                n_err++;
                $display("FAIL rr_tie%0d: got d_addr_ok=%b i_addr_ok=%b expected d=%b",
                         t, d_addr_ok, i_addr_ok, exp_d);
            end
        end
`endif

        // randomized traffic against the transaction model
        @(negedge clk);
        reset = 1; i_valid = 0; d_valid = 0; m_addr_ok = 0; m_data_ok = 0;
        mph = 0; own = 0; last_d = 0;
        e_addr = 0; e_size = 0; e_strb = 0; e_wdata = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          rst_now, mv, aok, done;
            logic [63:0] mrd;
            obs_t        exp;
            @(negedge clk);
            rst_now = ($urandom_range(299) == 0);
            if (!i_valid && $urandom_range(2) == 0) begin
                i_valid = 1; i_addr = {$urandom, $urandom};
            end
            if (!d_valid && $urandom_range(2) == 0) begin
                d_valid  = 1; d_addr = {$urandom, $urandom};
                d_size   = 3'($urandom_range(7));
                d_strobe = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
                d_wdata  = {$urandom, $urandom};
            end
            m_addr_ok = (mph == 1) && ($urandom_range(2) == 0);
            m_data_ok = (mph == 2) ? ($urandom_range(2) == 0)
                                   : (m_addr_ok && $urandom_range(3) == 0);
            mrd = {$urandom, $urandom};
            m_rdata = mrd;
            reset = rst_now;
            #1;
            mv   = (mph == 1);
            aok  = mv && m_addr_ok;
            done = (aok && m_data_ok) || (mph == 2 && m_data_ok);
            if (rst_now) exp = '0;
            else exp = mk(mv, mv && (e_strb != 0), mv ? e_addr : 64'h0,
                          mv ? e_size : 3'h0, mv ? e_strb : 8'h0, mv ? e_wdata : 64'h0,
                          aok && own == 1, done && own == 1, (done && own == 1) ? mrd : 64'h0,
                          aok && own == 2, done && own == 2, (done && own == 2) ? mrd : 64'h0);
            check($sformatf("rand%0d", c), exp);

            if (rst_now) begin
                mph = 0; own = 0; last_d = 0; i_valid = 0; d_valid = 0;
            end else begin
                if (mph == 0) begin
                    bit pick_d;
                    pick_d = d_valid && (!i_valid || !last_d);
`ifndef MEM_PORT_ARB_RR_EN
                    pick_d = d_valid;
`endif
                    if (pick_d) begin
                        mph = 1; own = 2;
                        e_addr = d_addr; e_size = d_size; e_strb = d_strobe; e_wdata = d_wdata;
                    end else if (i_valid) begin
                        mph = 1; own = 1;
                        e_addr = i_addr; e_size = MSIZE4; e_strb = 0; e_wdata = 0;
                    end
                end else if (mph == 1 && aok) begin
                    mph = m_data_ok ? 0 : 2;
                end else if (mph == 2 && m_data_ok) begin
                    mph = 0;
                end
                if (done) begin
                    last_d = (own == 2);
                    if (own == 1) i_valid = 0;
                    else d_valid = 0;
                    own = 0;
                end
            end
        end

        @(negedge clk);
        i_valid = 0; d_valid = 0; m_addr_ok = 0; m_data_ok = 0; reset = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
